// File: rtl/eeg_iir_mc.sv
// rtl/eeg_iir_mc.sv - time-multiplexed multi-channel EEG high-pass/low-pass IIR filter
// Optional saturation event counter (sat_cnt port) enabled by EEG_IIR_SATCNT_EN.
module eeg_iir_mc #(
  parameter int NCH           = 8,
  parameter int DATA_W        = 16,
  parameter int ACC_W         = 32,
  parameter int HP_SHIFT      = 6,
  parameter int LP_GAIN_SHIFT = 3,
  parameter int LP_SHIFT      = 5,
  parameter int OUT_SHIFT     = 8,
  localparam int CH_W         = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr_all,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic [CH_W-1:0]          s_chan,
  input  logic signed [DATA_W-1:0] s_data,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [CH_W-1:0]          m_chan,
  output logic signed [DATA_W-1:0] m_data,
  output logic                     m_sat,
  output logic                     bad_chan,
`ifdef EEG_IIR_SATCNT_EN
  output logic [15:0]              sat_cnt,
`endif
  output logic                     busy
);

  typedef enum logic [2:0] {CLEAR, IDLE, FETCH, CALC, OUT} state_t;

  localparam logic signed [ACC_W-1:0] MAX_OUT = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] MIN_OUT = ~MAX_OUT;

  state_t                     state_q, state_d;
  logic [CH_W-1:0]            clr_idx_q, clr_idx_d;
  logic                       clr_pend_q, clr_pend_d;
  logic [CH_W-1:0]            chan_q, chan_d;
  logic signed [DATA_W-1:0]   x_q, x_d;
  logic signed [ACC_W-1:0]    hp_old_q, hp_old_d, lp_old_q, lp_old_d;
  logic [CH_W-1:0]            m_chan_q, m_chan_d;
  logic signed [DATA_W-1:0]   m_data_q, m_data_d;
  logic                       m_sat_q, m_sat_d;
  logic                       bad_chan_q, bad_chan_d;

  logic signed [ACC_W-1:0]    hp_mem [NCH];
  logic signed [ACC_W-1:0]    lp_mem [NCH];
  logic                       mem_we;
  logic [CH_W-1:0]            mem_idx;
  logic signed [ACC_W-1:0]    hp_wdata, lp_wdata;

  logic signed [ACC_W-1:0]    x_ext, hp_new, lp_new, t_out;
  logic [31:0]                s_chan_ext;
  logic                       chan_ok;

  // Zero-extend before the range test so non-power-of-two NCH rejects the top codes.
  assign s_chan_ext = 32'(s_chan);
  assign chan_ok    = (s_chan_ext < 32'(NCH));

  always_comb begin
    state_d    = state_q;
    clr_idx_d  = clr_idx_q;
    clr_pend_d = clr_pend_q;
    chan_d     = chan_q;
    x_d        = x_q;
    hp_old_d   = hp_old_q;
    lp_old_d   = lp_old_q;
    m_chan_d   = m_chan_q;
    m_data_d   = m_data_q;
    m_sat_d    = m_sat_q;
    bad_chan_d = 1'b0;
    mem_we     = 1'b0;
    mem_idx    = clr_idx_q;
    hp_wdata   = '0;
    lp_wdata   = '0;

    x_ext  = {{(ACC_W-DATA_W){x_q[DATA_W-1]}}, x_q};
    hp_new = hp_old_q + x_ext - (hp_old_q >>> HP_SHIFT);
    lp_new = lp_old_q + (hp_new >>> LP_GAIN_SHIFT) - (lp_old_q >>> LP_SHIFT);
    t_out  = lp_new >>> OUT_SHIFT;

    case (state_q)
      CLEAR: begin
        mem_we     = 1'b1;
        clr_pend_d = 1'b0;
        if (clr_all) begin
          clr_idx_d = '0;
        end else if (clr_idx_q == CH_W'(NCH-1)) begin
          state_d = IDLE;
        end else begin
          clr_idx_d = clr_idx_q + 1'b1;
        end
      end
      IDLE: begin
        if (s_valid) begin
          chan_d = s_chan;
          x_d    = s_data;
        end
        // An accepted valid sample runs first; a clear in the same cycle waits behind it.
        if (s_valid && chan_ok) begin
          state_d    = FETCH;
          clr_pend_d = clr_all;
        end else if (clr_all) begin
          state_d   = CLEAR;
          clr_idx_d = '0;
        end
        if (s_valid && !chan_ok) bad_chan_d = 1'b1;
      end
      FETCH: begin
        hp_old_d = hp_mem[chan_q];
        lp_old_d = lp_mem[chan_q];
        state_d  = CALC;
        if (clr_all) clr_pend_d = 1'b1;
      end
      CALC: begin
        mem_we   = 1'b1;
        mem_idx  = chan_q;
        hp_wdata = hp_new;
        lp_wdata = lp_new;
        m_chan_d = chan_q;
        if (t_out > MAX_OUT) begin
          m_data_d = {1'b0, {(DATA_W-1){1'b1}}};
          m_sat_d  = 1'b1;
        end else if (t_out < MIN_OUT) begin
          m_data_d = {1'b1, {(DATA_W-1){1'b0}}};
          m_sat_d  = 1'b1;
        end else begin
          m_data_d = t_out[DATA_W-1:0];
          m_sat_d  = 1'b0;
        end
        state_d = OUT;
        if (clr_all) clr_pend_d = 1'b1;
      end
      OUT: begin
        if (clr_all) clr_pend_d = 1'b1;
        if (m_ready) begin
          if (clr_pend_q || clr_all) begin
            state_d    = CLEAR;
            clr_idx_d  = '0;
            clr_pend_d = 1'b0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = CLEAR;
    endcase
  end

`ifdef EEG_IIR_SATCNT_EN
  logic [15:0] sat_cnt_q, sat_cnt_d;

  always_comb begin
    sat_cnt_d = sat_cnt_q;
    if (clr_all) begin
      sat_cnt_d = '0;
    end else if (state_q == OUT && m_ready && m_sat_q && sat_cnt_q != 16'hFFFF) begin
      sat_cnt_d = sat_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) sat_cnt_q <= '0;
    else     sat_cnt_q <= sat_cnt_d;
  end

  assign sat_cnt = sat_cnt_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= CLEAR;
      clr_idx_q  <= '0;
      clr_pend_q <= 1'b0;
      chan_q     <= '0;
      x_q        <= '0;
      hp_old_q   <= '0;
      lp_old_q   <= '0;
      m_chan_q   <= '0;
      m_data_q   <= '0;
      m_sat_q    <= 1'b0;
      bad_chan_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      clr_idx_q  <= clr_idx_d;
      clr_pend_q <= clr_pend_d;
      chan_q     <= chan_d;
      x_q        <= x_d;
      hp_old_q   <= hp_old_d;
      lp_old_q   <= lp_old_d;
      m_chan_q   <= m_chan_d;
      m_data_q   <= m_data_d;
      m_sat_q    <= m_sat_d;
      bad_chan_q <= bad_chan_d;
    end
  end

  // Channel state is not reset directly; the CLEAR sweep zeroes it after every reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      hp_mem[mem_idx] <= hp_wdata;
      lp_mem[mem_idx] <= lp_wdata;
    end
  end

  assign s_ready  = (state_q == IDLE);
  assign busy     = (state_q != IDLE);
  assign m_valid  = (state_q == OUT);
  assign m_chan   = m_chan_q;
  assign m_data   = m_data_q;
  assign m_sat    = m_sat_q;
  assign bad_chan = bad_chan_q;

endmodule

// File: tb/tb_eeg_iir_mc.sv
// tb/tb_eeg_iir_mc.sv - randomized self-checking bench for eeg_iir_mc against a behavioural model
module tb_eeg_iir_mc;

  localparam int NCH    = 6;
  localparam int CH_W   = 3;
  localparam int DATA_W = 16;

  logic                     clk = 1'b0;
  logic                     rst = 1'b1;
  logic                     clr_all = 1'b0;
  logic                     s_valid = 1'b0;
  logic                     s_ready;
  logic [CH_W-1:0]          s_chan = '0;
  logic signed [DATA_W-1:0] s_data = '0;
  logic                     m_valid;
  logic                     m_ready = 1'b0;
  logic [CH_W-1:0]          m_chan;
  logic signed [DATA_W-1:0] m_data;
  logic                     m_sat;
  logic                     bad_chan;
  logic                     busy;
`ifdef EEG_IIR_SATCNT_EN
  logic [15:0]              sat_cnt;
`endif

  eeg_iir_mc #(
    .NCH(NCH), .DATA_W(DATA_W), .ACC_W(32), .HP_SHIFT(6),
    .LP_GAIN_SHIFT(3), .LP_SHIFT(5), .OUT_SHIFT(4)
  ) dut (
    .clk(clk), .rst(rst), .clr_all(clr_all),
    .s_valid(s_valid), .s_ready(s_ready), .s_chan(s_chan), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_chan(m_chan), .m_data(m_data),
    .m_sat(m_sat), .bad_chan(bad_chan),
`ifdef EEG_IIR_SATCNT_EN
    .sat_cnt(sat_cnt),
`endif
    .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;
  int hp_m [NCH];
  int lp_m [NCH];
  int sat_cnt_m = 0;

  task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    for (int i = 0; i < NCH; i++) begin
      hp_m[i] = 0;
      lp_m[i] = 0;
    end
  endtask

  // Filter equations evaluated in 32-bit signed int, which wraps like the accumulators.
  task automatic model_step(input int ch, input int x, output int exp_data, output bit exp_sat);
    int t;
    hp_m[ch] = hp_m[ch] + x - (hp_m[ch] >>> 6);
    lp_m[ch] = lp_m[ch] + (hp_m[ch] >>> 3) - (lp_m[ch] >>> 5);
    t = lp_m[ch] >>> 4;
    if (t > 32767)       begin exp_data = 32767;  exp_sat = 1'b1; end
    else if (t < -32768) begin exp_data = -32768; exp_sat = 1'b1; end
    else                 begin exp_data = t;      exp_sat = 1'b0; end
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!s_ready && n < 100) begin
      tick();
      n++;
    end
    if (n >= 100) check("ready_timeout", s_ready, 1);
  endtask

  task automatic count_sweep(input string tag);
    int n = 0;
    while (!s_ready && n < 50) begin
      if (m_valid !== 1'b0) check({tag, "_mvalid"}, m_valid, 0);
      tick();
      n++;
    end
    check(tag, n, NCH);
  endtask

  task automatic sat_account(input bit es);
    if (es && sat_cnt_m < 65535) sat_cnt_m++;
  endtask

  task automatic run_sample(input int ch, input int x, input bit clr, output int got);
    int  ed;
    bit  es;
    int  lat = 0;
    wait_ready();
    s_valid = 1'b1; s_chan = CH_W'(ch); s_data = DATA_W'(x); clr_all = clr;
    tick();
    s_valid = 1'b0; clr_all = 1'b0;
    if (clr) sat_cnt_m = 0;
    model_step(ch, x, ed, es);
    while (!m_valid && lat < 10) begin
      tick();
      lat++;
    end
    check("latency", lat, 2);
    check("m_chan", m_chan, ch);
    check("m_data", m_data, ed);
    check("m_sat", m_sat, es);
    got = m_data;
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    sat_account(es);
    if (clr) model_clear();
`ifdef EEG_IIR_SATCNT_EN
    check("sat_cnt", sat_cnt, sat_cnt_m);
`endif
  endtask

  initial begin
    int got;
    int ed;
    bit es;
    int lat;
    logic signed [15:0] rnd;

    // Reset and initial CLEAR sweep
    model_clear();
    tick(); tick();
    check("rst_s_ready", s_ready, 0);
    check("rst_m_valid", m_valid, 0);
    check("rst_m_data", m_data, 0);
    check("rst_m_sat", m_sat, 0);
    check("rst_bad_chan", bad_chan, 0);
    check("rst_busy", busy, 1);
    rst = 1'b0;
    count_sweep("rst_sweep");
    check("idle_busy", busy, 0);

    // Step on ch0
    run_sample(0, 1000, 1'b0, got);
    check("step1_const", got, 7);
    run_sample(0, 1000, 1'b0, got);
    check("step2_const", got, 23);

    // Channel independence
    run_sample(4, 1000, 1'b0, got);
    check("ind_ch4a", got, 7);
    run_sample(3, 1000, 1'b0, got);
    check("ind_ch3", got, 7);
    run_sample(4, 1000, 1'b0, got);
    check("ind_ch4b", got, 23);

    // Random samples on random channels
    for (int i = 0; i < 30; i++) begin
      rnd = 16'($urandom);
      run_sample(int'($urandom_range(0, NCH-1)), int'(rnd), 1'b0, got);
    end

    // Saturation, both polarities
    for (int i = 0; i < 40; i++) run_sample(1, 32767, 1'b0, got);
    check("sat_pos", got, 32767);
    check("sat_pos_flag", m_sat, 1);
    for (int i = 0; i < 40; i++) run_sample(2, -32768, 1'b0, got);
    check("sat_neg", got, -32768);
    check("sat_neg_flag", m_sat, 1);

    // Backpressure with clr_all during OUT
    wait_ready();
    s_valid = 1'b1; s_chan = 3'd0; s_data = 16'sd1000;
    tick();
    s_valid = 1'b0;
    model_step(0, 1000, ed, es);
    lat = 0;
    while (!m_valid && lat < 10) begin
      tick();
      lat++;
    end
    check("bp_latency", lat, 2);
    for (int i = 0; i < 10; i++) begin
      check("bp_m_valid", m_valid, 1);
      check("bp_m_data", m_data, ed);
      check("bp_s_ready", s_ready, 0);
      clr_all = (i == 3);
      tick();
      clr_all = 1'b0;
    end
    sat_cnt_m = 0;
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    sat_account(es);
    model_clear();
    count_sweep("bp_clr_sweep");
    run_sample(0, 1000, 1'b0, got);
    check("post_clr_ch0", got, 7);
    run_sample(5, -1000, 1'b0, got);
    check("post_clr_ch5", got, -8);

    // Bad channel
    wait_ready();
    s_valid = 1'b1; s_chan = 3'd7; s_data = 16'sd1234;
    tick();
    s_valid = 1'b0;
    check("bad_pulse", bad_chan, 1);
    check("bad_s_ready", s_ready, 1);
    check("bad_m_valid", m_valid, 0);
    tick();
    check("bad_pulse_end", bad_chan, 0);
    for (int i = 0; i < 4; i++) begin
      check("bad_no_out", m_valid, 0);
      tick();
    end
    for (int c = 0; c < NCH; c++) run_sample(c, 500, 1'b0, got);

    // clr_all together with an accepted sample
    run_sample(0, 2000, 1'b1, got);
    count_sweep("acc_clr_sweep");
    run_sample(0, 1000, 1'b0, got);
    check("acc_clr_fresh", got, 7);

    // Reset while an output is pending
    run_sample(3, 3000, 1'b0, got);
    wait_ready();
    s_valid = 1'b1; s_chan = 3'd3; s_data = 16'sd3000;
    tick();
    s_valid = 1'b0;
    tick(); tick();
    check("mid_m_valid", m_valid, 1);
    rst = 1'b1;
    tick();
    check("mid_rst_drop", m_valid, 0);
    check("mid_rst_data", m_data, 0);
    rst = 1'b0;
    model_clear();
    sat_cnt_m = 0;
    count_sweep("mid_rst_sweep");
    run_sample(3, 1000, 1'b0, got);
    check("mid_rst_fresh", got, 7);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/eeg_iir_mc.md
Name: eeg_iir_mc

Overview:
Time-multiplexed, multi-channel EEG bandpass filter. Each channel has a first-order high-pass stage followed by a first-order low-pass stage, with shift-only coefficients. Per-channel state is held in internal arrays, and one arithmetic datapath serves all channels. The block sits between the multi-channel ADC sample deserialiser and the feature extraction stages, with valid/ready handshakes on both sides.

Parameters:
NCH, 8, number of channels (2..64); CH_W = max(1, clog2(NCH)) is a derived localparam
DATA_W, 16, input/output sample width (signed two's complement)
ACC_W, 32, per-channel state accumulator width (signed); must be >= DATA_W+12
HP_SHIFT, 6, high-pass leak shift
LP_GAIN_SHIFT, 3, high-pass-to-low-pass gain shift
LP_SHIFT, 5, low-pass leak shift
OUT_SHIFT, 8, arithmetic right shift applied before output saturation

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
clr_all  in  1  one-cycle pulse; zeroes the state of every channel
s_valid  in  1  input sample valid
s_ready  out  1  block can accept a sample
s_chan  in  CH_W  channel index of input sample
s_data  in  DATA_W  input sample
m_valid  out  1  filtered output valid
m_ready  in  1  downstream accepts output
m_chan  out  CH_W  channel index of output
m_data  out  DATA_W  filtered, saturated output
m_sat  out  1  m_data was clamped (qualified by m_valid)
bad_chan  out  1  one-cycle pulse: sample accepted with s_chan >= NCH and dropped
busy  out  1  FSM not in IDLE

Behaviour:
- Reset is synchronous, active-high, on clk. Reset values: s_ready=0, m_valid=0, m_chan=0, m_data=0, m_sat=0, bad_chan=0, busy=1. After reset the FSM enters CLEAR.
- FSM states: CLEAR, IDLE, FETCH, CALC, OUT.
- CLEAR: writes hp=0 and lp=0 to one channel per cycle, index 0..NCH-1, then goes to IDLE. Takes exactly NCH cycles. s_ready=0, busy=1.
- IDLE: s_ready=1, busy=0. A sample is accepted when s_valid && s_ready; chan and data are latched.
  - If the accepted s_chan >= NCH: bad_chan pulses on the next cycle, the FSM stays in IDLE, and state is untouched.
  - Otherwise go to FETCH.
- FETCH: reads hp_old and lp_old for the latched channel (1 cycle).
- CALC: full-precision signed arithmetic, with x sign-extended to ACC_W. All >>> operations are arithmetic shifts.
  - hp_new = hp_old + x - (hp_old >>> HP_SHIFT)
  - lp_new = lp_old + (hp_new >>> LP_GAIN_SHIFT) - (lp_old >>> LP_SHIFT)
  - hp_new and lp_new are written back at the end of CALC.
  - Accumulators wrap at ACC_W and do not saturate internally.
  - t = lp_new >>> OUT_SHIFT. If t > 2^(DATA_W-1)-1, then m_data = max positive and m_sat=1. If t < -2^(DATA_W-1), then m_data = min negative and m_sat=1. Otherwise m_data = t[DATA_W-1:0] and m_sat=0.
- OUT: m_valid=1. m_chan, m_data and m_sat are held stable until m_ready. On m_valid && m_ready, go to IDLE.
- Latency: sample accepted at cycle T gives m_valid asserted at T+3 (FETCH T+1, CALC T+2, OUT T+3). Throughput is one sample per 4 cycles at best.
- s_ready is 0 in every state except IDLE. There is no input buffering.
- clr_all:
  - In IDLE, or with no pending operation: go to CLEAR, same sweep as reset.
  - In FETCH, CALC or OUT: the pending clear is registered. The current sample completes normally through the OUT handshake, and the FSM then enters CLEAR instead of IDLE.
  - In CLEAR: the sweep restarts from channel 0.
- clr_all asserted on the same cycle as an accepted sample in IDLE: the sample is accepted and processed first, then CLEAR runs.
- Reset mid-operation: pending output discarded, m_valid drops the next cycle, full CLEAR sweep.
- Channels are fully independent. Processing channel k never modifies the state of any other channel.

Optional Feature:
Macro EEG_IIR_SATCNT_EN.
- Defined: adds output port sat_cnt (16 bits). It increments on every OUT handshake with m_sat=1, saturates at 16'hFFFF, and is cleared by rst or clr_all.
- Not defined: port absent, no counter logic; all other behaviour identical.

Test Plan:
- Reset: rst for 2 cycles then release -> s_ready=0 for exactly 8 cycles (NCH=8), then s_ready=1; m_valid=0 throughout.
- Step, defaults, ch0: x=1000 twice -> first output m_data=0 (lp=125), second m_data=1 (hp=1985, lp=370); each m_valid arrives 3 cycles after acceptance.
- Independence: ch0 x=1000, ch3 x=1000, ch0 x=1000 -> ch3 output m_data=0 (fresh state), second ch0 output m_data=1; m_chan matches each input.
- Saturation, OUT_SHIFT=4: ch1 x=+32767 repeated 40 times -> m_data=32767 with m_sat=1 once clamped; x=-32768 on ch2 repeated -> m_data=-32768, m_sat=1; sat_cnt counts matching handshakes when the macro is defined.
- Backpressure and clear: hold m_ready=0 for 10 cycles with clr_all pulsed during OUT -> m_data stable, s_ready=0; after the handshake, CLEAR runs 8 cycles and the next ch0 x=1000 output is m_data=0.
- Bad channel, NCH=6: s_chan=7 -> bad_chan pulses once, no m_valid, s_ready stays 1; state of ch0..ch5 unchanged.
